// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch front-end: memory index width,
// fetch FSM encodings and the default boot PC.
package instr_fetch_unit_pkg;

   localparam int ADDR_WIDTH = 10;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory read port plus decode-side instruction handshake.
// master is the fetch unit; slave is the memory/decode side.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) ();

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_req_valid;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_data_valid;

   logic                  instr_valid;
   logic [DATA_WIDTH-1:0] instr;
   logic [31:0]           instr_pc;
   logic                  instr_ready;

   modport master (
      output mem_addr, mem_req_valid, mem_we,
      input  mem_rdata, mem_data_valid,
      output instr_valid, instr, instr_pc,
      input  instr_ready
   );

   modport slave (
      input  mem_addr, mem_req_valid, mem_we,
      output mem_rdata, mem_data_valid,
      input  instr_valid, instr, instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Instruction buffer holding {pc, instr} entries; head is read
// combinationally, flush clears it in one cycle.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding word read at a time into a small
// buffer drained by decode; redirects flush and retarget the PC.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                fetch_en,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   instr_fetch_unit_if.master  bus
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = 32 + DATA_WIDTH;

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [31:0]   pc;
   logic [31:0]   pc_nx;
   logic          drop;
   logic          drop_nx;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nx;
   logic          full;
   logic          empty;
   logic [EW-1:0] head;
   logic          resp;
   logic          push;
   logic          pop;
   logic          space;

   assign resp  = (state == S_RESP) && bus.mem_data_valid;
   assign push  = resp && !drop && !redirect_valid;
   assign pop   = !empty && bus.instr_ready && !redirect_valid;

   assign count_nx = redirect_valid ? '0
                   : count + CW'(push) - CW'(pop);
   // Any new request must fit alongside what the buffer will hold.
   assign space = (count_nx < CW'(FIFO_DEPTH));

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .wdata ({pc, bus.mem_rdata}),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      drop_nx  = drop;
      unique case (state)
         S_IDLE: begin
            if (fetch_en && (!full || pop || redirect_valid))
               state_nx = S_REQ;
         end
         S_REQ: begin
            state_nx = S_RESP;
         end
         S_RESP: begin
            if (bus.mem_data_valid) begin
               drop_nx  = 1'b0;
               if (push)
                  pc_nx = pc + 32'd4;
               state_nx = (fetch_en && space) ? S_REQ : S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      // Only a response still pending after this cycle needs dropping.
      if (redirect_valid) begin
         pc_nx   = word_align(redirect_pc);
         drop_nx = (state == S_REQ)
                || ((state == S_RESP) && !bus.mem_data_valid);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         drop  <= 1'b0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         drop  <= drop_nx;
      end
   end

   assign bus.mem_addr      = pc[ADDR_WIDTH+1:2];
   assign bus.mem_req_valid = (state == S_REQ);
   assign bus.mem_we        = 1'b0;
   assign bus.instr_valid   = !empty;
   assign bus.instr         = empty ? '0 : head[DATA_WIDTH-1:0];
   assign bus.instr_pc      = empty ? '0 : head[EW-1:DATA_WIDTH];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front-end fetch stage that sits directly upstream of the instruction/data memory and feeds decode. It holds the PC and issues single-word read requests to the memory, one outstanding at a time. Returned words go into a small FIFO that decode drains through a valid/ready handshake. Branch redirects flush the FIFO and retarget the PC.

Parameters:
DATA_WIDTH, 32, instruction/memory word width.
FIFO_DEPTH, 4, instruction buffer entries; must be a power of 2 and at least 2.
RESET_PC, 32'h0000_0000, PC value after reset (byte address).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_en  in  1  fetch enable; while low, no new requests are issued
redirect_valid  in  1  one-cycle PC redirect pulse (branch/jump resolved)
redirect_pc  in  32  redirect target byte address; bits [1:0] are ignored
mem_addr  out  `ADDR_WIDTH  word address to memory, equal to pc[`ADDR_WIDTH+1:2]
mem_req_valid  out  1  read request strobe
mem_we  out  1  tied 0; this unit only reads
mem_rdata  in  DATA_WIDTH  read data from memory
mem_data_valid  in  1  memory response valid
instr_valid  out  1  FIFO head valid
instr  out  DATA_WIDTH  FIFO head instruction
instr_pc  out  32  byte PC of FIFO head
instr_ready  in  1  decode accepts the head this cycle

Behaviour:
- Reset (async): state=S_IDLE, pc=RESET_PC, FIFO empty, drop=0. Outputs: mem_req_valid=0, mem_addr=RESET_PC word index, instr_valid=0, instr=0, instr_pc=0.
- Memory contract: a request driven in cycle N produces data sampled at the end of cycle N+1. The response is accepted only if, in S_RESP, mem_data_valid=1. If mem_data_valid=0, stay in S_RESP; there is no timeout.
- FSM:
  - S_IDLE: go to S_REQ when fetch_en=1 and there is space.
  - S_REQ: mem_req_valid=1 for exactly one cycle, then go to S_RESP.
  - S_RESP: on mem_data_valid:
    - If drop=0, push {pc, mem_rdata} and set pc+=4.
    - Clear drop.
    - Next state is S_REQ if fetch_en and space remain, else S_IDLE.
- Space: a request is issued only if count < FIFO_DEPTH, counting the in-flight entry. This makes a push always succeed.
- Throughput: at most 1 instruction per 2 cycles.
- Decode handshake:
  - A pop happens when instr_valid && instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - instr and instr_pc are the FIFO head (combinational read), and are stable while instr_valid=1 and instr_ready=0.
- Redirect (highest priority):
  - FIFO is flushed (count=0) and pc={redirect_pc[31:2],2'b00}.
  - Any pop in that cycle is discarded.
  - If the state is S_RESP, or S_REQ is transitioning to S_RESP, set drop=1 so the in-flight response is discarded and not pushed.
  - A response arriving in the same cycle as the redirect is dropped.
  - The next request uses the new pc.
- PC arithmetic: 32-bit, wraps modulo 2^32. mem_addr truncates to `ADDR_WIDTH bits, so memory indexing wraps.
- fetch_en deasserted mid-request: the in-flight response is still completed and pushed; no further requests are issued.
- Reset mid-operation: immediate return to reset state; the in-flight response is ignored.

Decomposition:
- Shared header with system_param.vh (`ADDR_WIDTH already there). Add the fetch FSM state encodings (S_IDLE=2'd0, S_REQ=2'd1, S_RESP=2'd2) and `RESET_PC default there.
- One sub-module: fetch_fifo.
  - Parameters: WIDTH, DEPTH.
  - Features: synchronous push/pop, flush, count, full/empty, async reset, combinational head read.
  - Holds {pc, instr} entries with WIDTH=32+DATA_WIDTH.

Test Plan:
- Reset, then fetch_en=1, instr_ready=1, memory preloaded with the Fibonacci program -> instr/instr_pc sequence 00100293@0x0, 00500313@0x4, 00000393@0x8, 00100e13@0xC, 007e0eb3@0x10. mem_req_valid pulses every 2 cycles.
- instr_ready=0 with fetch_en=1 -> exactly 4 words are buffered (0x0..0xC), mem_req_valid stays 0, pc=0x10. Head stays 00100293. Raising instr_ready drains in order and fetch resumes at 0x10.
- redirect_valid with redirect_pc=0x13 asserted while in S_RESP, FIFO holding 2 entries -> FIFO empties and the in-flight response is dropped. The next instruction delivered is 007e0eb3@0x10.
- Simultaneous push, pop and redirect to 0x20 in one cycle -> count=0, no entry from the old stream appears, next request has mem_addr=8.
- mem_data_valid held low for 5 cycles in S_RESP -> FSM holds, no extra requests; the word is accepted when it rises. Then assert reset mid-wait -> all outputs return to reset values on the same cycle and fetch restarts at RESET_PC.
- redirect_pc=0xFFFF_FFFC -> PC wraps to 0x0 after the fetch. mem_addr shows the truncated index, then 0.
